// File: rtl/usb_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// usb_tx_scheduler_if
//   Bundles the signals between the TX bank scheduler and its surroundings.
//   These are the bank-complete inputs from the command decoder side, the FIFO
//   status and done handshake, and the start-of-packet outputs to the
//   slave-FIFO controller.
//
//   Parameter:
//     BADDR_NBIT  bank address width (2**BADDR_NBIT banks)
//
//   Signals:
//     wr_eop       bank-complete level, asynchronous to the scheduler clock
//     wr_baddr     bank just completed
//     f_full       EP6 full flag, active high
//     tx_done      one-cycle pulse: current bank fully sent
//     tx_sop       one-cycle start-of-packet strobe
//     tx_baddr     bank being sent
//     pending      pending-bank bitmap
//     overrun      sticky: bank re-completed while still pending
//     timeout_err  one-cycle pulse when a transfer is abandoned
//
//   Modports:
//     master  environment side (drives wr_*, f_full, tx_done)
//     slave   scheduler side
// ----------------------------------------------------------------------------
interface usb_tx_scheduler_if #(
    parameter int BADDR_NBIT = 3
);
    logic                       wr_eop;
    logic [BADDR_NBIT-1:0]      wr_baddr;
    logic                       f_full;
    logic                       tx_done;
    logic                       tx_sop;
    logic [BADDR_NBIT-1:0]      tx_baddr;
    logic [2**BADDR_NBIT-1:0]   pending;
    logic                       overrun;
    logic                       timeout_err;

    modport master (
        output wr_eop, wr_baddr, f_full, tx_done,
        input  tx_sop, tx_baddr, pending, overrun, timeout_err
    );

    modport slave (
        input  wr_eop, wr_baddr, f_full, tx_done,
        output tx_sop, tx_baddr, pending, overrun, timeout_err
    );
endinterface

// File: rtl/usb_tx_scheduler.sv
// ----------------------------------------------------------------------------
// usb_tx_scheduler
//   Schedules TX buffer banks towards the USB slave-FIFO controller.
//
//   The bank-complete level from the command decoder clock domain is
//   synchronised, and its rising edge marks the addressed bank as pending.
//   One start-of-packet is then issued per pending bank. Bank 0 (handshake)
//   has strict priority and ignores the FIFO full flag. Data banks
//   1..2**BADDR_NBIT-1 are served round-robin and only while the FIFO is
//   not full.
//
//   Parameters:
//     BADDR_NBIT  bank address width
//     TIMEOUT     clock cycles allowed per transfer (timeout build only)
//
//   Ports:
//     usb_clk  scheduler clock
//     rst      synchronous active-high reset
//     bus      usb_tx_scheduler_if.slave (see interface file for signals)
//
//   Optional feature macro: USB_TX_TIMEOUT_EN
//     When defined, a transfer that sees no tx_done within TIMEOUT cycles is
//     abandoned and timeout_err pulses. When undefined, BUSY waits
//     indefinitely and timeout_err is tied low.
// ----------------------------------------------------------------------------
module usb_tx_scheduler #(
    parameter int BADDR_NBIT = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     usb_clk,
    input  logic                     rst,
    usb_tx_scheduler_if.slave        bus
);

    localparam int NBANK = 2**BADDR_NBIT;
    localparam int NDATA = NBANK - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOP  = 2'd1,
        BUSY = 2'd2
    } state_t;

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("usb_tx_scheduler: TIMEOUT must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input capture: 3-flop synchroniser, registered rising-edge strobe
    // ------------------------------------------------------------------
    logic [2:0]            p_q;
    logic                  rise_q;
    logic [BADDR_NBIT-1:0] baddr_q;

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            p_q     <= 3'b000;
            rise_q  <= 1'b0;
            baddr_q <= '0;
        end else begin
            p_q    <= {p_q[1:0], bus.wr_eop};
            rise_q <= (p_q[2:1] == 2'b01);
            // The bank address is stable well beyond this point.
            if (p_q[2:1] == 2'b01) begin
                baddr_q <= bus.wr_baddr;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and scheduling registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [BADDR_NBIT-1:0] tx_baddr_q, sel_d;
    logic [BADDR_NBIT-1:0] last_q;
    logic [NBANK-1:0]      pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  tx_sop_q;
    logic                  expire;

    logic [NBANK-1:0]      set_vec;
    logic [NBANK-1:0]      clr_vec;

    // Per-bank set/clear. A set in the same cycle as the clear of that bank
    // keeps it pending, and such a collision is not an overrun.
    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            assign set_vec[gi] = rise_q && (baddr_q == BADDR_NBIT'(gi));
            assign clr_vec[gi] = (state_q == SOP) && (tx_baddr_q == BADDR_NBIT'(gi));
        end
    endgenerate

    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        overrun_d = overrun_q | (|(set_vec & pending_q & ~clr_vec));
    end

    // ------------------------------------------------------------------
    // Round-robin candidate ring over the data banks.
    // cand[k] is the k-th bank after last_q, wrapping NDATA -> 1 and
    // never visiting bank 0.
    // ------------------------------------------------------------------
    logic [BADDR_NBIT-1:0] cand     [1:NDATA];
    logic [NDATA:1]        eligible;

    generate
        for (gi = 1; gi <= NDATA; gi++) begin : g_ring
            logic [BADDR_NBIT:0] sum;
            assign sum          = {1'b0, last_q} + (BADDR_NBIT+1)'(gi);
            assign cand[gi]     = (sum > (BADDR_NBIT+1)'(NDATA))
                                  ? BADDR_NBIT'(sum - (BADDR_NBIT+1)'(NDATA))
                                  : BADDR_NBIT'(sum);
            assign eligible[gi] = pending_q[cand[gi]];
        end
    endgenerate

    logic                  rr_found;
    logic [BADDR_NBIT-1:0] rr_sel;

    // Scan from farthest to nearest; the nearest eligible candidate is
    // written last and therefore wins.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int i = NDATA; i >= 1; i--) begin
            if (eligible[i]) begin
                rr_found = 1'b1;
                rr_sel   = cand[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional transfer timeout
    // ------------------------------------------------------------------
`ifdef USB_TX_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_q == SOP) begin
            tmo_q <= '0;
        end else if (state_q == BUSY) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // A tx_done arriving on the expiry cycle completes the transfer normally.
    assign expire = (state_q == BUSY) && (tmo_q == TW'(TIMEOUT - 1)) && !bus.tx_done;
`else
    assign expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = tx_baddr_q;
        case (state_q)
            IDLE: begin
                if (pending_q[0]) begin
                    state_d = SOP;
                    sel_d   = '0;
                end else if (rr_found && !bus.f_full) begin
                    state_d = SOP;
                    sel_d   = rr_sel;
                end
            end
            SOP: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.tx_done || expire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_baddr_q <= '0;
            last_q     <= BADDR_NBIT'(NDATA);
            pending_q  <= '0;
            overrun_q  <= 1'b0;
            tx_sop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_baddr_q <= sel_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            tx_sop_q   <= (state_d == SOP);
            // The handshake bank does not advance the data ring.
            if (state_q == SOP && tx_baddr_q != '0) begin
                last_q <= tx_baddr_q;
            end
        end
    end

    assign bus.tx_sop      = tx_sop_q;
    assign bus.tx_baddr    = tx_baddr_q;
    assign bus.pending     = pending_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = expire;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_usb_tx_scheduler
//   Directed bench for usb_tx_scheduler (BADDR_NBIT=3, TIMEOUT=16).
//   A negedge monitor logs every tx_sop (bank, cycle) and timeout_err pulse;
//   the directed sequence pops these logs and compares them against
//   hand-computed expectations through the check task.
// ----------------------------------------------------------------------------
module tb_usb_tx_scheduler;

    localparam int BN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_tx_scheduler_if #(.BADDR_NBIT(BN)) bus ();

    usb_tx_scheduler #(
        .BADDR_NBIT (BN),
        .TIMEOUT    (16)
    ) dut (
        .usb_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sop_bank_q [$];
    int sop_cyc_q  [$];
    int tmo_cyc_q  [$];
    int t_sop;
    int t_dummy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_sop) begin
            sop_bank_q.push_back(int'(bus.tx_baddr));
            sop_cyc_q.push_back(cyc);
        end
        if (bus.timeout_err) begin
            tmo_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Complete one bank: raise wr_eop with the address held, then drop it
    // long enough for the next rise to be seen.
    task automatic eop(input int bank);
        bus.wr_baddr = BN'(bank);
        bus.wr_eop   = 1'b1;
        ticks(4);
        bus.wr_eop   = 1'b0;
        ticks(3);
    endtask

    task automatic done_pulse();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
    endtask

    task automatic expect_sop(input int bank, input string tag, output int at_cyc);
        int waited;
        int b;
        waited = 0;
        at_cyc = -1;
        while (sop_bank_q.size() == 0 && waited < 80) begin
            tick();
            waited++;
        end
        check({tag, "_seen"}, 32'(sop_bank_q.size() != 0), 32'd1);
        if (sop_bank_q.size() != 0) begin
            b      = sop_bank_q.pop_front();
            at_cyc = sop_cyc_q.pop_front();
            check({tag, "_bank"}, 32'(b), 32'(bank));
        end
    endtask

    initial begin
        bus.wr_eop   = 1'b0;
        bus.wr_baddr = '0;
        bus.f_full   = 1'b0;
        bus.tx_done  = 1'b0;
        rst          = 1'b1;
        ticks(3);

        // ---------------- reset state ----------------
        check("rst_sop",     32'(bus.tx_sop),      32'd0);
        check("rst_baddr",   32'(bus.tx_baddr),    32'd0);
        check("rst_pending", 32'(bus.pending),     32'd0);
        check("rst_overrun", 32'(bus.overrun),     32'd0);
        check("rst_tmo",     32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        ticks(2);

        // ---------------- T1: latency, bank 3 ----------------
        bus.wr_baddr = 3'd3;
        bus.wr_eop   = 1'b1;
        ticks(4);                      // after edge 3
        check("t1_pend_e3", 32'(bus.pending), 32'h08);
        check("t1_sop_e3",  32'(bus.tx_sop),  32'd0);
        tick();                        // after edge 4
        check("t1_sop_e4",   32'(bus.tx_sop),   32'd1);
        check("t1_baddr_e4", 32'(bus.tx_baddr), 32'd3);
        tick();                        // after edge 5
        check("t1_sop_e5",  32'(bus.tx_sop),  32'd0);
        check("t1_pend_e5", 32'(bus.pending), 32'h00);
        bus.wr_eop = 1'b0;
        check("t1_log_cnt", 32'(sop_bank_q.size()), 32'd1);
        sop_bank_q.delete();
        sop_cyc_q.delete();
        done_pulse();
        ticks(2);

        // ---------------- T2: round robin while busy on 6 ----------------
        eop(6);
        expect_sop(6, "t2_b6", t_dummy);
        eop(2);
        eop(5);
        eop(1);
        check("t2_pend",  32'(bus.pending),       32'h26);
        check("t2_nosop", 32'(sop_bank_q.size()), 32'd0);
        done_pulse();
        expect_sop(1, "t2_b1", t_dummy);
        ticks(5);
        check("t2_wait1", 32'(sop_bank_q.size()), 32'd0);
        done_pulse();
        expect_sop(2, "t2_b2", t_dummy);
        ticks(5);
        check("t2_wait2", 32'(sop_bank_q.size()), 32'd0);
        done_pulse();
        expect_sop(5, "t2_b5", t_dummy);
        done_pulse();
        check("t2_pend_end", 32'(bus.pending), 32'h00);

        // ---------------- T3: handshake priority over full ----------------
        bus.f_full = 1'b1;
        eop(4);
        ticks(3);
        check("t3_blocked", 32'(sop_bank_q.size()), 32'd0);
        check("t3_pend4",   32'(bus.pending),       32'h10);
        eop(0);
        expect_sop(0, "t3_b0", t_dummy);
        done_pulse();
        ticks(10);
        check("t3_still_blk", 32'(sop_bank_q.size()), 32'd0);
        check("t3_pend_left", 32'(bus.pending),       32'h10);
        bus.f_full = 1'b0;
        expect_sop(4, "t3_b4", t_dummy);
        done_pulse();
        check("t3_overrun", 32'(bus.overrun), 32'd0);

        // ---------------- T4: overrun ----------------
        bus.f_full = 1'b1;
        eop(2);
        eop(2);
        check("t4_overrun", 32'(bus.overrun), 32'd1);
        check("t4_pend",    32'(bus.pending), 32'h04);
        bus.f_full = 1'b0;
        expect_sop(2, "t4_b2", t_dummy);
        done_pulse();
        ticks(10);
        check("t4_once",   32'(sop_bank_q.size()), 32'd0);
        check("t4_sticky", 32'(bus.overrun),       32'd1);

        // ---------------- T5: timeout ----------------
        eop(3);
        expect_sop(3, "t5_b3", t_sop);
        eop(5);
        check("t5_pend", 32'(bus.pending), 32'h20);
`ifdef USB_TX_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (tmo_cyc_q.size() == 0 && waited < 60) begin
                tick();
                waited++;
            end
            check("t5_tmo_seen", 32'(tmo_cyc_q.size()), 32'd1);
            if (tmo_cyc_q.size() != 0) begin
                check("t5_tmo_delay", 32'(tmo_cyc_q.pop_front() - t_sop), 32'd16);
            end
        end
        tick();
        check("t5_tmo_width", 32'(bus.timeout_err), 32'd0);
        expect_sop(5, "t5_b5", t_dummy);
        done_pulse();
        check("t5_tmo_total", 32'(tmo_cyc_q.size()), 32'd0);
`else
        ticks(40);
        check("t5_no_tmo",   32'(tmo_cyc_q.size()),  32'd0);
        check("t5_held",     32'(sop_bank_q.size()), 32'd0);
        check("t5_pend_hld", 32'(bus.pending),       32'h20);
        done_pulse();
        expect_sop(5, "t5_b5", t_dummy);
        done_pulse();
`endif

        // ---------------- T6: reset during busy ----------------
        eop(1);
        expect_sop(1, "t6_b1", t_dummy);
        eop(2);
        eop(3);
        eop(4);
        check("t6_pend", 32'(bus.pending), 32'h1C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_sop",     32'(bus.tx_sop),      32'd0);
        check("t6_baddr",   32'(bus.tx_baddr),    32'd0);
        check("t6_pending", 32'(bus.pending),     32'd0);
        check("t6_overrun", 32'(bus.overrun),     32'd0);
        check("t6_tmo",     32'(bus.timeout_err), 32'd0);
        ticks(20);
        check("t6_quiet", 32'(sop_bank_q.size()), 32'd0);
        eop(6);
        expect_sop(6, "t6_b6", t_dummy);
        done_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
